// File: rtl/pattern_scheduler.sv
// Test-pattern sequencer: picks one generator's RGB per frame, switching only at frame
// boundaries with a full black frame between patterns, and registers the result to the DAC.
module pattern_scheduler #(
    parameter int unsigned H       = 1280,
    parameter int unsigned V       = 1024,
    parameter int unsigned NUM_PAT = 3,
    parameter int unsigned DWELL   = 60
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        disp_en,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        btn_next,
    input  logic        auto_en,
    input  logic [95:0] pat_rgb,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [1:0]  sel,
    output logic        blanking
);

    localparam logic [10:0] XLast   = 11'(H - 1);
    localparam logic [10:0] YLast   = 11'(V - 1);
    localparam logic [1:0]  SelLast = 2'(NUM_PAT - 1);
    localparam logic [7:0]  CntLast = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        StShow,
        StPending,
        StBlank
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  next_sel_q, next_sel_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        btn_q;
    logic [23:0] rgb_q, rgb_d;

    logic        eof;
    logic        btn_rise;
    logic        adv;
    logic [1:0]  inc_sel;
    logic [3:0][23:0] src;

    assign src = pat_rgb;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        next_sel_d  = next_sel_q;
        frame_cnt_d = frame_cnt_q;

        eof      = disp_en && (x == XLast) && (y == YLast);
        btn_rise = btn_next & ~btn_q;
        adv      = btn_rise | (auto_en && (frame_cnt_q == CntLast) && eof);
        inc_sel  = (sel_q == SelLast) ? 2'd0 : sel_q + 2'd1;

        unique case (state_q)
            StShow: begin
                if (adv) begin
                    // Advance coinciding with the boundary skips straight to the black frame.
                    next_sel_d  = inc_sel;
                    frame_cnt_d = 8'd0;
                    state_d     = eof ? StBlank : StPending;
                end else if (eof && (frame_cnt_q != 8'hFF)) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            StPending: begin
                if (eof) state_d = StBlank;
            end
            StBlank: begin
                if (eof) begin
                    state_d     = StShow;
                    sel_d       = next_sel_q;
                    frame_cnt_d = 8'd0;
                end
            end
            default: state_d = StShow;
        endcase

        rgb_d = (state_q != StBlank && disp_en) ? src[sel_q] : 24'd0;
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state_q     <= StShow;
            sel_q       <= 2'd0;
            next_sel_q  <= 2'd0;
            frame_cnt_q <= 8'd0;
            btn_q       <= 1'b0;
            rgb_q       <= 24'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            next_sel_q  <= next_sel_d;
            frame_cnt_q <= frame_cnt_d;
            btn_q       <= btn_next;
            rgb_q       <= rgb_d;
        end
    end

    assign {r, g, b} = rgb_q;
    assign sel       = sel_q;
    assign blanking  = (state_q == StBlank);

endmodule

// File: tb/tb_pattern_scheduler.sv
// Scoreboard bench for pattern_scheduler: a per-frame table of hand-derived modes drives a tiny
// raster; expected outputs are queued at drive time and checked by an independent monitor.
module tb_pattern_scheduler;

    localparam int LineLen   = 10;
    localparam int FramePix  = 50;
    localparam int NumFrames = 23;
    localparam int Blank     = 3;

    logic        clk = 1'b0;
    logic        reset, disp_en, btn_next, auto_en;
    logic [10:0] x, y;
    logic [95:0] pat_rgb;
    logic [7:0]  r, g, b;
    logic [1:0]  sel;
    logic        blanking;

    always #5 clk = ~clk;

    pattern_scheduler #(
        .H(8), .V(4), .NUM_PAT(3), .DWELL(2)
    ) dut (
        .VGA_CLK (clk),
        .reset   (reset),
        .disp_en (disp_en),
        .x       (x),
        .y       (y),
        .btn_next(btn_next),
        .auto_en (auto_en),
        .pat_rgb (pat_rgb),
        .r       (r),
        .g       (g),
        .b       (b),
        .sel     (sel),
        .blanking(blanking)
    );

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic [1:0]  sel;
        logic        blank;
        int          frame;
        int          pix;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Frame modes: 0..2 = pattern shown, 3 = black frame.
    int mode_t [NumFrames] = '{0, 0, 0, 3, 1, 3, 2, 3, 0, 3, 1, 1, 3, 2, 2, 3, 0, 0, 0, 3, 1, 3, 0};
    int auto_t [NumFrames] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int pulse_t [NumFrames][3];

    function automatic logic [23:0] col(input int m);
        case (m)
            0:       col = 24'hFF0000;
            1:       col = 24'h00FF00;
            2:       col = 24'h0000FF;
            default: col = 24'h000000;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: the DUT presents an output every cycle; compare whatever is due now.
    initial forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({r, g, b} !== e.rgb || sel !== e.sel || blanking !== e.blank) begin
                errors++;
                if (errors < 30)
                    $display("FAIL pix f%0d p%0d: got rgb=%06h sel=%0d blank=%0b, want rgb=%06h sel=%0d blank=%0b",
                             e.frame, e.pix, {r, g, b}, sel, blanking, e.rgb, e.sel, e.blank);
            end
        end
    end

    task automatic drive(input logic rst_v, input logic de, input int xv, input int yv,
                         input logic bt, input logic ae, input logic [23:0] e_rgb,
                         input logic [1:0] e_sel, input logic e_blank, input int f, input int p);
        exp_t e;
        reset    = rst_v;
        disp_en  = de;
        x        = 11'(xv);
        y        = 11'(yv);
        btn_next = bt;
        auto_en  = ae;
        e.due    = cyc + 1;
        e.rgb    = e_rgb;
        e.sel    = e_sel;
        e.blank  = e_blank;
        e.frame  = f;
        e.pix    = p;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int cur, nxt, sel_hold, smode, pmode, xv, yv;
        logic de, is_eof, after, bt, rst_v;
        logic [23:0] e_rgb;
        logic [1:0]  e_sel;
        logic        e_blank;

        foreach (pulse_t[i, j]) pulse_t[i][j] = -1;
        pulse_t[2][0]  = 12;                                        // mid-frame request
        pulse_t[3][0]  = 5;   pulse_t[3][1] = 20;                   // ignored during black frame
        pulse_t[4][0]  = 3;   pulse_t[4][1] = 6;  pulse_t[4][2] = 9; // only one advance
        pulse_t[6][0]  = 20;                                        // wrap 2 -> 0
        pulse_t[8][0]  = 37;                                        // coincides with eof
        pulse_t[18][0] = 10;
        pulse_t[20][0] = 10;                                        // sets up next_sel = 2

        pat_rgb = {24'h123456, 24'h0000FF, 24'h00FF00, 24'hFF0000};

        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 9, 4, 1'b0, 1'b0, 24'd0, 2'd0, 1'b0, -1, i);

        sel_hold = 0;
        for (int f = 0; f < NumFrames; f++) begin
            cur   = mode_t[f];
            nxt   = (f + 1 < NumFrames) ? mode_t[f + 1] : mode_t[f];
            after = 1'b0;
            if (cur != Blank) sel_hold = cur;
            for (int p = 0; p < FramePix; p++) begin
                xv     = p % LineLen;
                yv     = p / LineLen;
                de     = (xv < 8) && (yv < 4);
                is_eof = de && xv == 7 && yv == 3;
                bt     = 1'b0;
                for (int k = 0; k < 3; k++) if (pulse_t[f][k] == p) bt = 1'b1;
                rst_v  = (f == 21 && p == 15);
                if (rst_v) begin
                    e_rgb   = 24'd0;
                    e_sel   = 2'd0;
                    e_blank = 1'b0;
                end else begin
                    smode   = after ? nxt : cur;
                    pmode   = (after || is_eof) ? nxt : cur;
                    e_rgb   = (de && smode != Blank) ? col(smode) : 24'd0;
                    e_sel   = (pmode == Blank) ? 2'(sel_hold) : 2'(pmode);
                    e_blank = (pmode == Blank);
                end
                drive(rst_v, de, xv, yv, bt, auto_t[f] != 0, e_rgb, e_sel, e_blank, f, p);
                if (rst_v) begin
                    cur      = 0;
                    sel_hold = 0;
                end
                if (is_eof) after = 1'b1;
            end
        end

        btn_next = 1'b0;
        disp_en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
- Sequences the VGA test-pattern generators (border frame, quadrants, gradient, ...). Selects one pattern's r/g/b per frame and registers it towards the DAC.
- Pattern changes come from a push-button or an auto-advance frame timer. A change is applied only at a frame boundary, with one full black frame inserted between patterns.
- Sits between the pattern generators and the VGA output pins, in the VGA_CLK domain.

Parameters:
- H, 1280, active pixels per line.
- V, 1024, active lines per frame.
- NUM_PAT, 3, number of patterns in use (2..4); selection wraps after NUM_PAT-1.
- DWELL, 60, frames a pattern is shown before auto-advance (1..255).

Ports:
- VGA_CLK  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- disp_en  in  1  active-video flag from the timing generator.
- x  in  11  current pixel column.
- y  in  11  current pixel row.
- btn_next  in  1  already-synchronised button level; the rising edge requests the next pattern.
- auto_en  in  1  1 = auto-advance every DWELL frames.
- pat_rgb  in  96  four packed 24-bit sources; source k = bits [24k+23:24k], ordered {r,g,b} MSB first.
- r  out  8  red to DAC.
- g  out  8  green to DAC.
- b  out  8  blue to DAC.
- sel  out  2  index of the pattern currently displayed.
- blanking  out  1  1 while the inter-pattern black frame is in progress.

Behaviour:
- Clocking and reset: everything updates on posedge VGA_CLK. Reset is synchronous and active-high.
- Reset values: r=g=b=0, sel=0, blanking=0, state=SHOW, frame_cnt=0, btn_q=0, next_sel=0.
- Button edge: btn_q registers btn_next every cycle. btn_rise = btn_next & ~btn_q.
- Frame boundary: eof = disp_en && x==H-1 && y==V-1. This is a single-cycle combinational strobe.
- Frame counter: 8-bit frame_cnt increments on each eof in SHOW. It clears to 0 on every transition out of SHOW and on reset. It saturates at 255.
- Advance request: adv = btn_rise | (auto_en && frame_cnt==DWELL-1 && eof).
- State machine:
  - SHOW:
    - adv with no eof in the same cycle -> PENDING, next_sel = (sel==NUM_PAT-1) ? 0 : sel+1.
    - adv and eof in the same cycle -> BLANK directly, with the same next_sel.
  - PENDING:
    - further adv pulses are ignored (not queued; next_sel unchanged).
    - on eof -> BLANK.
  - BLANK:
    - blanking=1; r/g/b forced to 0.
    - btn_rise is ignored.
    - on eof -> SHOW, sel <= next_sel, blanking <= 0, frame_cnt <= 0.
- Output path:
  - One register stage. In SHOW/PENDING with disp_en=1: {r,g,b} <= pat_rgb source[sel]. Otherwise 0.
  - Pattern inputs must be aligned to x/y; the block adds exactly 1 cycle of latency relative to them.
- Switch timing: sel and blanking change in the cycle after eof. The first pixel of the next frame is therefore already governed by the new state.
- Sources at index >= NUM_PAT are never selected.
- Reset mid-frame or mid-BLANK returns immediately to pattern 0 in SHOW; the next cycle's output follows source 0.

Test Plan:
- Reset, then run frames with H=8, V=4, NUM_PAT=3, sources 0/1/2 = 24'hFF0000 / 24'h00FF00 / 24'h0000FF, btn idle, auto_en=0 -> sel stays 0; r=FF, g=b=0 on every active pixel; outputs 0 whenever disp_en=0.
- Single btn_next pulse mid-frame 0 -> PENDING; frame 0 completes red. Cycle after eof: blanking=1 and frame 1 is all zeros. Cycle after the next eof: sel=1, blanking=0, frame 2 is green.
- Three pulses within one frame -> only one advance (sel 0->1). Button edges during BLANK are also ignored.
- auto_en=1, DWELL=2 -> sel sequence per frame: 0,0,blank,1,1,blank,2,2,blank,0 (wrap-around at NUM_PAT-1).
- btn_rise coincident with the eof cycle -> skips PENDING; the next frame is BLANK with next_sel = sel+1.
- Assert reset during BLANK with next_sel=2 -> next cycle: sel=0, blanking=0, r=g=b=0. Following active pixels follow source 0.
